temp_monitor: RTL and testbench

Parametrised successor to the board's on-die temperature display path. Sequences the FPGA temperature-sense diode (clear, enable, wait for done), averages 2^AVG_LOG samples, and tracks min/max. Raises an over-temperature alarm with hysteresis and flags a sensor timeout. Drives NUM_DIGITS active-low seven-segment digits in a selectable display mode; instantiated in the board top level next to the SoC's temperature-sense conduit.

---
 rtl/temp_monitor_pkg.sv | 39 +++
 rtl/temp_monitor_bcd.sv | 52 +++++
 rtl/temp_monitor.sv | 237 +++++++++++++++++++++++
 tb/tb_temp_monitor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_monitor_pkg.sv
// temp_monitor shared types: sequencer states, display modes,
// and the active-low seven-segment digit table (gfedcba).
package temp_monitor_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CLEAR,
    ST_ENABLE,
    ST_CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    MODE_AVG,
    MODE_MAX,
    MODE_MIN,
    MODE_RAW
  } mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/temp_monitor_bcd.sv
// bin2bcd_seq: sequential 8-bit double-dabble, 1 load + 8 shift cycles.
// Ports: clk, rst, i_start, i_bin -> o_busy, o_done (last busy cycle), o_bcd.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [11:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++)
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      // cnt == 8: result is final, hand it over this cycle
      if (r_cnt == 4'd8) begin
        r_busy <= 1'b0;
      end else begin
        {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
        r_cnt <= r_cnt + 4'd1;
      end
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == 4'd8);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/temp_monitor.sv
// temp_monitor: sensor sequencer, averaging, min/max, alarm, 7-seg display.
// Ports: clk, rst, temp_valid/val in, temp_en/clear out, mode, clear_stats,
// alarm, sensor_fault, hex_d (active-low segs), hex_dp (active-low dots).
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int AVG_LOG         = 2,
  parameter int SAMPLE_INTERVAL = 5_000_000,
  parameter int TIMEOUT         = 1_000_000,
  parameter int TEMP_OFFSET     = 128,
  parameter int ALARM_HI        = 85,
  parameter int ALARM_LO        = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    temp_valid,
  input  logic [7:0]              temp_val,
  output logic                    temp_en,
  output logic                    temp_clear,
  input  logic [1:0]              mode,
  input  logic                    clear_stats,
  output logic                    alarm,
  output logic                    sensor_fault,
  output logic [7*NUM_DIGITS-1:0] hex_d,
  output logic [NUM_DIGITS-1:0]   hex_dp
);

  localparam int ACC_W = 8 + AVG_LOG;
  localparam int NSAMP = 1 << AVG_LOG;
  localparam int LIMIT = 10 ** NUM_DIGITS;
  localparam int SAT   = (LIMIT > 256) ? 255 : LIMIT - 1;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic        w_timeout;
  logic [2:0]  r_sync;
  logic        w_rise;
  logic [7:0]  r_code;
  logic [8:0]  w_diff;
  logic [7:0]  w_c;
  logic [ACC_W-1:0] r_acc, w_sum;
  logic [4:0]  r_n;
  logic [7:0]  r_avg, r_last, r_min, r_max;
  logic        r_avg_new, r_avg_ok, r_last_ok;
  logic        r_mm_ok, r_mm_pend;
  logic        r_alarm, r_fault;
  logic [7:0]  w_sel, w_disp;
  logic        w_sel_ok;
  logic [8:0]  w_key, r_key;
  logic [1:0]  r_kmode;
  logic        w_start, w_busy, w_done;
  logic [11:0] w_bcd;
  logic [7*NUM_DIGITS-1:0] w_hex_nxt, r_hex;

  // 2-FF synchroniser plus one stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[1:0], temp_valid};
  end
  assign w_rise = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout   = 1'b0;
    temp_en     = 1'b0;
    temp_clear  = 1'b0;
    unique case (r_state)
      ST_WAIT: begin
        if (r_cnt == 32'(SAMPLE_INTERVAL - 1)) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_CLEAR: begin
        temp_clear  = 1'b1;
        w_state_nxt = ST_ENABLE;
        w_cnt_nxt   = '0;
      end
      ST_ENABLE: begin
        temp_en = 1'b1;
        if (w_rise) begin
          w_state_nxt = ST_CAPTURE;
        end else if (r_cnt == 32'(TIMEOUT - 1)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  // negative result (bit 8 set) saturates to 0 degC
  assign w_diff = {1'b0, r_code} - 9'(TEMP_OFFSET);
  assign w_c    = w_diff[8] ? 8'd0 : w_diff[7:0];
  assign w_sum  = r_acc + ACC_W'(w_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code    <= '0;
      r_acc     <= '0;
      r_n       <= '0;
      r_avg     <= '0;
      r_avg_new <= 1'b0;
      r_avg_ok  <= 1'b0;
      r_last    <= '0;
      r_last_ok <= 1'b0;
    end else begin
      r_avg_new <= 1'b0;
      if (r_state == ST_ENABLE && w_rise)
        r_code <= temp_val;
      if (r_state == ST_CAPTURE) begin
        r_last    <= w_c;
        r_last_ok <= 1'b1;
        if (r_n == 5'(NSAMP - 1)) begin
          r_avg     <= 8'(w_sum >> AVG_LOG);
          r_avg_ok  <= 1'b1;
          r_avg_new <= 1'b1;
          r_acc     <= '0;
          r_n       <= '0;
        end else begin
          r_acc <= w_sum;
          r_n   <= r_n + 5'd1;
        end
      end
    end
  end

  // a clear that collides with a fresh average defers that average by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min     <= '0;
      r_max     <= '0;
      r_mm_ok   <= 1'b0;
      r_mm_pend <= 1'b0;
      r_alarm   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (clear_stats) begin
        r_min     <= '0;
        r_max     <= '0;
        r_mm_ok   <= 1'b0;
        r_mm_pend <= r_avg_new;
      end else if (r_avg_new || r_mm_pend) begin
        r_mm_pend <= 1'b0;
        r_mm_ok   <= 1'b1;
        if (!r_mm_ok || r_avg < r_min) r_min <= r_avg;
        if (!r_mm_ok || r_avg > r_max) r_max <= r_avg;
      end
      if (r_avg_new) begin
        if (r_avg >= 8'(ALARM_HI))      r_alarm <= 1'b1;
        else if (r_avg <= 8'(ALARM_LO)) r_alarm <= 1'b0;
      end
      if (w_timeout)        r_fault <= 1'b1;
      else if (clear_stats) r_fault <= 1'b0;
    end
  end

  always_comb begin
    w_sel    = r_avg;
    w_sel_ok = r_avg_ok;
    unique case (mode_t'(mode))
      MODE_AVG: begin w_sel = r_avg;  w_sel_ok = r_avg_ok;  end
      MODE_MAX: begin w_sel = r_max;  w_sel_ok = r_mm_ok;   end
      MODE_MIN: begin w_sel = r_min;  w_sel_ok = r_mm_ok;   end
      MODE_RAW: begin w_sel = r_last; w_sel_ok = r_last_ok; end
    endcase
  end

  assign w_disp  = ({24'd0, w_sel} >= 32'(LIMIT)) ? 8'(SAT) : w_sel;
  assign w_key   = {w_sel_ok, w_disp};
  assign w_start = !w_busy && (w_key != r_key || mode != r_kmode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key   <= '0;
      r_kmode <= '0;
      r_hex   <= '1;
    end else begin
      if (w_start) begin
        r_key   <= w_key;
        r_kmode <= mode;
      end
      if (w_done)
        r_hex <= w_hex_nxt;
    end
  end

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (w_disp),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // r_key[8] holds the validity of the value being converted
  always_comb begin
    w_hex_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_key[8] && (i == 0 || (w_bcd >> (4*i)) != 12'd0))
        w_hex_nxt[7*i +: 7] = bcd_to_seg(w_bcd[4*i +: 4]);
  end

  always_comb begin
    hex_dp    = '1;
    hex_dp[0] = ~r_alarm;
    hex_dp[1] = ~r_fault;
  end

  assign hex_d        = r_hex;
  assign alarm        = r_alarm;
  assign sensor_fault = r_fault;

endmodule

// File: tb/tb_temp_monitor.sv
// Bench for temp_monitor: sensor model, randomized samples, reference model.
// Two instances (2 and 3 digits) share all inputs and run in lockstep.
module tb_temp_monitor;

  localparam int SI = 60;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic temp_valid;
  logic [7:0] temp_val;
  logic [1:0] mode = 2'd0;
  logic clear_stats = 1'b0;
  logic en0, clr0, alarm0, fault0;
  logic [13:0] hex0;
  logic [1:0] dp0;
  logic en1, clr1, alarm1, fault1;
  logic [20:0] hex1;
  logic [2:0] dp1;

  int n_checks = 0;
  int n_fail = 0;

  int s_code = 153;
  int s_delay = 20;
  bit s_mute = 1'b0;
  int scnt = 0;

  int m_sum, m_n, m_avg, m_min, m_max, m_last;
  bit m_avg_ok, m_mm_ok, m_alarm, m_last_ok, m_fault;

  always #5 clk = ~clk;

  temp_monitor #(
    .NUM_DIGITS(2), .AVG_LOG(2), .SAMPLE_INTERVAL(SI), .TIMEOUT(TO),
    .TEMP_OFFSET(128), .ALARM_HI(85), .ALARM_LO(80)
  ) u_dut2 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_val(temp_val),
    .temp_en(en0), .temp_clear(clr0), .mode(mode),
    .clear_stats(clear_stats), .alarm(alarm0), .sensor_fault(fault0),
    .hex_d(hex0), .hex_dp(dp0)
  );

  temp_monitor #(
    .NUM_DIGITS(3), .AVG_LOG(2), .SAMPLE_INTERVAL(SI), .TIMEOUT(TO),
    .TEMP_OFFSET(128), .ALARM_HI(85), .ALARM_LO(80)
  ) u_dut3 (
    .clk(clk), .rst(rst), .temp_valid(temp_valid), .temp_val(temp_val),
    .temp_en(en1), .temp_clear(clr1), .mode(mode),
    .clear_stats(clear_stats), .alarm(alarm1), .sensor_fault(fault1),
    .hex_d(hex1), .hex_dp(dp1)
  );

  // sensor: raises done s_delay cycles after enable, drops it with enable
  initial begin
    temp_valid = 1'b0;
    temp_val = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (en0 !== 1'b1) begin
        temp_valid = 1'b0;
        scnt = 0;
      end else if (!s_mute && !temp_valid) begin
        scnt++;
        if (scnt >= s_delay) begin
          temp_val = 8'(s_code);
          temp_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(int v, bit ok, int nd);
    logic [20:0] r;
    int p;
    int x;
    r = '1;
    x = v;
    if (ok) begin
      if (x >= 10**nd) x = 10**nd - 1;
      p = 1;
      for (int i = 0; i < nd; i++) begin
        if (i == 0 || x >= p) r[7*i +: 7] = seg((x / p) % 10);
        p = p * 10;
      end
    end
    return r;
  endfunction

  function automatic logic [20:0] exp_disp(int md, int nd);
    case (md)
      0: return exp_hex(m_avg, m_avg_ok, nd);
      1: return exp_hex(m_max, m_mm_ok, nd);
      2: return exp_hex(m_min, m_mm_ok, nd);
      default: return exp_hex(m_last, m_last_ok, nd);
    endcase
  endfunction

  function automatic void model_reset();
    m_sum = 0; m_n = 0; m_avg = 0; m_min = 0; m_max = 0; m_last = 0;
    m_avg_ok = 0; m_mm_ok = 0; m_alarm = 0; m_last_ok = 0; m_fault = 0;
  endfunction

  function automatic void m_capture(int code);
    int c;
    c = code - 128;
    if (c < 0) c = 0;
    m_last = c;
    m_last_ok = 1;
    m_sum += c;
    m_n++;
    if (m_n == 4) begin
      m_avg = m_sum / 4;
      m_avg_ok = 1;
      m_sum = 0;
      m_n = 0;
      if (!m_mm_ok) begin
        m_min = m_avg;
        m_max = m_avg;
      end else begin
        if (m_avg < m_min) m_min = m_avg;
        if (m_avg > m_max) m_max = m_avg;
      end
      m_mm_ok = 1;
      if (m_avg >= 85) m_alarm = 1;
      else if (m_avg <= 80) m_alarm = 0;
    end
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // runs one sensor sequence; returns in the CAPTURE (or post-timeout) cycle
  task automatic run_sample(input int code, input int dly,
                            output int en_cyc, output int clr_cyc);
    bit seen;
    bit done;
    s_code = code;
    s_delay = dly;
    en_cyc = 0;
    clr_cyc = 0;
    seen = 0;
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      if (en0 === 1'b1) begin
        seen = 1;
        en_cyc++;
      end else if (seen) begin
        done = 1;
      end
      if (clr0 === 1'b1) clr_cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL seq_bound: sequence did not complete, en_cycles=%0d", en_cyc);
    end else if (s_mute) begin
      m_fault = 1;
    end else begin
      m_capture(code);
    end
  endtask

  task automatic block4(input int code);
    int e, c;
    for (int k = 0; k < 4; k++) run_sample(code, $urandom_range(3, 40), e, c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL rst_en got=%b want=0", en0); end
    n_checks++; if (clr0 !== 1'b0) begin n_fail++; $display("FAIL rst_clear got=%b want=0", clr0); end
    n_checks++; if (alarm0 !== 1'b0) begin n_fail++; $display("FAIL rst_alarm got=%b want=0", alarm0); end
    n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%b want=0", fault0); end
    n_checks++; if (hex0 !== 14'h3fff) begin n_fail++; $display("FAIL rst_hex got=%h want=3fff", hex0); end
    n_checks++; if (dp0 !== 2'b11) begin n_fail++; $display("FAIL rst_dp got=%b want=11", dp0); end
    n_checks++; if (hex1 !== 21'h1fffff) begin n_fail++; $display("FAIL rst_hex3 got=%h want=1fffff", hex1); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int e, c;
    logic [20:0] x;
    for (int k = 0; k < 4; k++) begin
      run_sample(153, 20, e, c);
      n_checks++; if (c !== 1) begin n_fail++; $display("FAIL clear_pulse sample %0d got=%0d want=1", k, c); end
    end
    tick(12);
    x = exp_hex(25, 1, 2);
    n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL disp25 got=%h want=%h", hex0, x[13:0]); end
    n_checks++; if (alarm0 !== 1'b0) begin n_fail++; $display("FAIL alarm25 got=%b want=0", alarm0); end
  endtask

  task automatic test_timeout();
    int e, c;
    s_mute = 1'b1;
    run_sample(0, 0, e, c);
    s_mute = 1'b0;
    n_checks++; if (e !== TO) begin n_fail++; $display("FAIL timeout_len got=%0d want=%0d", e, TO); end
    n_checks++; if (fault0 !== 1'b1) begin n_fail++; $display("FAIL fault_set got=%b want=1", fault0); end
    n_checks++; if (dp0[1] !== 1'b0) begin n_fail++; $display("FAIL dp1_fault got=%b want=0", dp0[1]); end
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    m_fault = 0;
    m_mm_ok = 0;
    n_checks++; if (fault0 !== 1'b0) begin n_fail++; $display("FAIL fault_clear got=%b want=0", fault0); end
    n_checks++; if (dp0[1] !== 1'b1) begin n_fail++; $display("FAIL dp1_clear got=%b want=1", dp0[1]); end
  endtask

  task automatic test_alarm();
    int tgt [4] = '{84, 86, 82, 80};
    bit want [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit prev;
    int e, c;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) run_sample(tgt[i] + 128, $urandom_range(3, 40), e, c);
      run_sample(tgt[i] + 128, $urandom_range(3, 40), e, c);
      tick(1);
      n_checks++; if (alarm0 !== prev) begin n_fail++; $display("FAIL alarm_early avg %0d got=%b want=%b", tgt[i], alarm0, prev); end
      tick(1);
      n_checks++; if (alarm0 !== want[i]) begin n_fail++; $display("FAIL alarm avg %0d got=%b want=%b", tgt[i], alarm0, want[i]); end
      prev = want[i];
    end
  endtask

  task automatic test_random();
    int e, c;
    logic [20:0] x;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) run_sample($urandom_range(90, 250), $urandom_range(3, 40), e, c);
      tick(12);
      x = exp_disp(0, 2);
      n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL rand_disp avg=%0d got=%h want=%h", m_avg, hex0, x[13:0]); end
      n_checks++; if (alarm0 !== m_alarm) begin n_fail++; $display("FAIL rand_alarm avg=%0d got=%b want=%b", m_avg, alarm0, m_alarm); end
      n_checks++; if (dp0 !== {~m_fault, ~m_alarm}) begin n_fail++; $display("FAIL rand_dp got=%b want=%b", dp0, {~m_fault, ~m_alarm}); end
    end
  endtask

  task automatic test_minmax();
    int avgs [3] = '{30, 50, 40};
    int md [3] = '{1, 2, 0};
    logic [20:0] x, old;
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    m_mm_ok = 0;
    for (int i = 0; i < 3; i++) block4(avgs[i] + 128);
    tick(12);
    x = exp_disp(0, 2);
    n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL mm_avg40 got=%h want=%h", hex0, x[13:0]); end
    old = x;
    for (int i = 0; i < 3; i++) begin
      mode = 2'(md[i]);
      x = exp_disp(md[i], 2);
      tick(9);
      n_checks++; if (hex0 !== old[13:0]) begin n_fail++; $display("FAIL mode%0d_early got=%h want=%h", md[i], hex0, old[13:0]); end
      tick(1);
      n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL mode%0d got=%h want=%h", md[i], hex0, x[13:0]); end
      old = x;
    end
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    m_mm_ok = 0;
    block4(45 + 128);
    tick(12);
    for (int i = 1; i <= 2; i++) begin
      mode = 2'(i);
      tick(10);
      x = exp_hex(45, 1, 2);
      n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL mm45 mode%0d got=%h want=%h", i, hex0, x[13:0]); end
    end
    mode = 2'd0;
    tick(12);
  endtask

  task automatic test_saturation();
    int codes [4] = '{248, 100, 137, 255};
    int e, c;
    logic [20:0] x;
    mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      run_sample(codes[i], $urandom_range(3, 40), e, c);
      tick(12);
      x = exp_disp(3, 2);
      n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL sat2 code %0d got=%h want=%h", codes[i], hex0, x[13:0]); end
      x = exp_disp(3, 3);
      n_checks++; if (hex1 !== x) begin n_fail++; $display("FAIL sat3 code %0d got=%h want=%h", codes[i], hex1, x); end
    end
    mode = 2'd0;
    tick(12);
  endtask

  task automatic test_reset_mid();
    int e, c;
    int k;
    logic [20:0] x;
    s_delay = 30;
    k = 0;
    while (en0 !== 1'b1 && k < 500) begin
      tick(1);
      k++;
    end
    n_checks++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_en got=%b want=1", en0); end
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    n_checks++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_en got=%b want=0", en0); end
    n_checks++; if (clr0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got=%b want=0", clr0); end
    n_checks++; if (alarm0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_alarm got=%b want=0", alarm0); end
    n_checks++; if (hex0 !== 14'h3fff) begin n_fail++; $display("FAIL rstmid_hex got=%h want=3fff", hex0); end
    n_checks++; if (dp0 !== 2'b11) begin n_fail++; $display("FAIL rstmid_dp got=%b want=11", dp0); end
    run_sample(153, 10, e, c);
    n_checks++; if (c !== 1) begin n_fail++; $display("FAIL restart_clear got=%0d want=1", c); end
    for (int i = 0; i < 3; i++) run_sample($urandom_range(128, 230), $urandom_range(3, 40), e, c);
    tick(12);
    x = exp_disp(0, 2);
    n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL restart_disp got=%h want=%h", hex0, x[13:0]); end
    mode = 2'd1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    n_checks++; if (hex0 !== 14'h3fff) begin n_fail++; $display("FAIL rstbcd_hex got=%h want=3fff", hex0); end
    n_checks++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL rstbcd_en got=%b want=0", en0); end
    tick(15);
    n_checks++; if (hex0 !== 14'h3fff) begin n_fail++; $display("FAIL rstbcd_blank got=%h want=3fff", hex0); end
    mode = 2'd0;
    for (int i = 0; i < 4; i++) run_sample($urandom_range(128, 230), $urandom_range(3, 40), e, c);
    tick(12);
    x = exp_disp(0, 2);
    n_checks++; if (hex0 !== x[13:0]) begin n_fail++; $display("FAIL rstbcd_disp got=%h want=%h", hex0, x[13:0]); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_timeout();
    test_alarm();
    test_random();
    test_minmax();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
